roundtrip_tester: RTL and testbench

Parametrised multi-channel stimulus/response round-trip tester for chained-gate co-simulation benches. Each channel toggles a stimulus wire that drives a gate chain under test, waits for the chain output to reach the expected level, measures round-trip latency in clock cycles, and flags timeouts and glitches. It generalises a fixed single-chain inverter loop to N independent chains. It adds chain-parity selection, iteration counts, continuous mode, and per-channel statistics.

---
 rtl/roundtrip_tester_if.sv | 27 ++
 rtl/roundtrip_tester.sv | 127 ++++++++++++
 tb/tb_roundtrip_tester.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/roundtrip_tester_if.sv
// roundtrip_tester_if: run control, chain stimulus/response and per-channel statistics bundle
interface roundtrip_tester_if #(
    parameter int CHANNELS = 4,
    parameter int LAT_W    = 8,
    parameter int CNT_W    = 16
);
    logic                      start;
    logic                      stop;
    logic                      mode;
    logic [CNT_W-1:0]          iterations;
    logic [CHANNELS-1:0]       stim;
    logic [CHANNELS-1:0]       resp;
    logic                      busy;
    logic                      done;
    logic [CHANNELS-1:0]       err_timeout;
    logic [CHANNELS-1:0]       err_glitch;
    logic [CHANNELS*LAT_W-1:0] lat_max;
    logic [CHANNELS*CNT_W-1:0] rt_count;
    modport master (
        output start, stop, mode, iterations, resp,
        input  stim, busy, done, err_timeout, err_glitch, lat_max, rt_count
    );
    modport slave (
        input  start, stop, mode, iterations, resp,
        output stim, busy, done, err_timeout, err_glitch, lat_max, rt_count
    );
endinterface

// File: rtl/roundtrip_tester.sv
// roundtrip_tester: N-channel gate-chain stimulus/response tester measuring round-trip latency,
// timeouts and glitches on synchronised chain outputs.
module roundtrip_tester #(
    parameter int CHANNELS = 4,
    parameter int INVERT   = 1,
    parameter int LAT_W    = 8,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 200
) (
    input logic               clk,
    input logic               rst_n,
    roundtrip_tester_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, SETTLE, DONE} state_t;
    localparam logic             INV      = 1'(INVERT);
    localparam logic [LAT_W-1:0] TMO_LAST = LAT_W'(TIMEOUT - 1);
    state_t              st_q   [CHANNELS];
    state_t              st_d   [CHANNELS];
    logic [LAT_W-1:0]    lat_q  [CHANNELS];
    logic [LAT_W-1:0]    lat_d  [CHANNELS];
    logic [LAT_W-1:0]    lmax_q [CHANNELS];
    logic [LAT_W-1:0]    lmax_d [CHANNELS];
    logic [CNT_W-1:0]    rt_q   [CHANNELS];
    logic [CNT_W-1:0]    rt_d   [CHANNELS];
    logic [CHANNELS-1:0] stim_q, stim_d, s1_q, s1_d, s2_q, s2_d;
    logic [CHANNELS-1:0] tmo_q, tmo_d, gl_q, gl_d;
    logic [CNT_W-1:0]    iter_q, iter_d;
    logic                mode_q, mode_d, stop_q, stop_d;
    logic                busy, done_all;
    always_comb begin
        busy     = 1'b0;
        done_all = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            busy     = busy | (st_q[i] == WAIT) | (st_q[i] == SETTLE);
            done_all = done_all & (st_q[i] == DONE);
        end
    end
    // All channels leave IDLE together, so run-wide settings are captured once.
    always_comb begin
        s1_d   = bus.resp;
        s2_d   = s1_q;
        stim_d = stim_q;
        tmo_d  = tmo_q;
        gl_d   = gl_q;
        stop_d = busy & (stop_q | bus.stop);
        iter_d = (st_q[0] == IDLE && bus.start) ? bus.iterations : iter_q;
        mode_d = (st_q[0] == IDLE && bus.start) ? bus.mode : mode_q;
        for (int i = 0; i < CHANNELS; i++) begin
            st_d[i]   = st_q[i];
            lat_d[i]  = lat_q[i];
            lmax_d[i] = lmax_q[i];
            rt_d[i]   = rt_q[i];
            case (st_q[i])
                IDLE: if (bus.start) begin
                    lmax_d[i] = '0;
                    rt_d[i]   = '0;
                    lat_d[i]  = '0;
                    tmo_d[i]  = 1'b0;
                    gl_d[i]   = 1'b0;
                    st_d[i]   = (!bus.mode && bus.iterations == '0) ? DONE : WAIT;
                    stim_d[i] = (!bus.mode && bus.iterations == '0) ? stim_q[i] : ~stim_q[i];
                end
                WAIT: if (s2_q[i] == (stim_q[i] ^ INV)) begin
                    lmax_d[i] = (lat_q[i] > lmax_q[i]) ? lat_q[i] : lmax_q[i];
                    rt_d[i]   = (&rt_q[i]) ? rt_q[i] : rt_q[i] + 1'b1;
                    st_d[i]   = SETTLE;
                end else if (lat_q[i] == TMO_LAST) begin
                    tmo_d[i] = 1'b1;
                    st_d[i]  = DONE;
                end else begin
                    lat_d[i] = lat_q[i] + 1'b1;
                end
                SETTLE: begin
                    gl_d[i] = gl_q[i] | (s2_q[i] != (stim_q[i] ^ INV));
                    if (mode_q ? stop_q : (rt_q[i] == iter_q)) begin
                        st_d[i] = DONE;
                    end else begin
                        stim_d[i] = ~stim_q[i];
                        lat_d[i]  = '0;
                        st_d[i]   = WAIT;
                    end
                end
                DONE: st_d[i] = (done_all && !bus.start) ? IDLE : DONE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]   <= IDLE;
                lat_q[i]  <= '0;
                lmax_q[i] <= '0;
                rt_q[i]   <= '0;
            end
            stim_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            tmo_q  <= '0;
            gl_q   <= '0;
            iter_q <= '0;
            mode_q <= 1'b0;
            stop_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            lat_q  <= lat_d;
            lmax_q <= lmax_d;
            rt_q   <= rt_d;
            stim_q <= stim_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            tmo_q  <= tmo_d;
            gl_q   <= gl_d;
            iter_q <= iter_d;
            mode_q <= mode_d;
            stop_q <= stop_d;
        end
    end
    assign bus.stim        = stim_q;
    assign bus.busy        = busy;
    assign bus.done        = done_all;
    assign bus.err_timeout = tmo_q;
    assign bus.err_glitch  = gl_q;
    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign bus.lat_max[g*LAT_W +: LAT_W]  = lmax_q[g];
        assign bus.rt_count[g*CNT_W +: CNT_W] = rt_q[g];
    end
endmodule

// File: tb/tb_roundtrip_tester.sv
// tb_roundtrip_tester: directed runs of roundtrip_tester against modelled inverting chains
// with per-channel delay, stuck outputs and injected pulses.
module tb_roundtrip_tester;
    localparam int CH = 4;
    localparam int LW = 8;
    localparam int CW = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    roundtrip_tester_if #(.CHANNELS(CH), .LAT_W(LW), .CNT_W(CW)) bus ();
    roundtrip_tester #(.CHANNELS(CH), .INVERT(1), .LAT_W(LW), .CNT_W(CW), .TIMEOUT(200)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    int             dly [CH];
    logic [15:0]    hist [CH];
    logic [CH-1:0]  tie_en, tie_val, glitch;
    int             tog [CH];
    int             t0 [CH];
    logic [CH-1:0]  prev = '0;
    int             total = 0;
    int             bad = 0;
    int             n;
    always @(posedge clk)
        for (int i = 0; i < CH; i++) hist[i] <= {hist[i][14:0], bus.stim[i]};
    always_comb begin
        bus.resp = '0;
        for (int i = 0; i < CH; i++)
            bus.resp[i] = tie_en[i] ? tie_val[i]
                        : ((dly[i] == 0 ? bus.stim[i] : hist[i][dly[i]-1]) ^ 1'b1 ^ glitch[i]);
    end
    initial for (int i = 0; i < CH; i++) tog[i] = 0;
    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) if (bus.stim[i] !== prev[i]) tog[i] = tog[i] + 1;
        prev = bus.stim;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    function automatic logic [LW-1:0] lm(input int i);
        return bus.lat_max[i*LW +: LW];
    endfunction
    function automatic logic [CW-1:0] rc(input int i);
        return bus.rt_count[i*CW +: CW];
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic go(input logic m, input logic [CW-1:0] it);
        bus.mode = m;
        bus.iterations = it;
        for (int i = 0; i < CH; i++) t0[i] = tog[i];
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic wait_done(output int cnt, input int lim);
        cnt = 0;
        while (!bus.done && cnt < lim) begin
            tick();
            cnt++;
        end
        chk("done_reached", 32'(bus.done), 1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.mode = 1'b0;
        bus.iterations = '0;
        tie_en = '0;
        tie_val = '0;
        glitch = '0;
        for (int i = 0; i < CH; i++) dly[i] = 0;
        repeat (3) tick();
        chk("rst_stim", 32'(bus.stim), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'({bus.err_timeout, bus.err_glitch}), 0);
        chk("rst_latmax", 32'(bus.lat_max), 0);
        chk("rst_rtcount", bus.rt_count[31:0], 0);
        rst_n = 1'b1;
        repeat (5) tick();
        // zero-delay loopback, 5 iterations
        go(1'b0, 16'd5);
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_stim_first", 32'(bus.stim), 32'hf);
        wait_done(n, 400);
        chk("t1_cycles", 32'(n), 20);
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("t1_lat%0d", i), 32'(lm(i)), 2);
            chk($sformatf("t1_rt%0d", i), 32'(rc(i)), 5);
            chk($sformatf("t1_tog%0d", i), 32'(tog[i] - t0[i]), 5);
        end
        chk("t1_err", 32'({bus.err_timeout, bus.err_glitch}), 0);
        tick();
        chk("t1_idle_done", 32'(bus.done), 0);
        chk("t1_idle_busy", 32'(bus.busy), 0);
        // channel 1 stuck low while its expected level is high
        tie_en[1] = 1'b1;
        tie_val[1] = 1'b0;
        repeat (6) tick();
        go(1'b0, 16'd5);
        wait_done(n, 400);
        chk("t3_cycles", 32'(n), 200);
        chk("t3_tmo", 32'(bus.err_timeout), 32'b0010);
        chk("t3_rt1", 32'(rc(1)), 0);
        chk("t3_rt0", 32'(rc(0)), 5);
        chk("t3_lat1", 32'(lm(1)), 0);
        chk("t3_tog1", 32'(tog[1] - t0[1]), 1);
        chk("t3_stim", 32'(bus.stim), 0);
        tick();
        tie_en = '0;
        repeat (10) tick();
        // channel 2 delayed 7 cycles
        dly[2] = 7;
        repeat (10) tick();
        go(1'b0, 16'd5);
        wait_done(n, 400);
        chk("t2_cycles", 32'(n), 55);
        chk("t2_lat2", 32'(lm(2)), 9);
        chk("t2_lat0", 32'(lm(0)), 2);
        chk("t2_lat3", 32'(lm(3)), 2);
        chk("t2_rt2", 32'(rc(2)), 5);
        chk("t2_tmo_cleared", 32'(bus.err_timeout), 0);
        tick();
        dly[2] = 0;
        repeat (10) tick();
        // pulse on channel 0 lands in its first SETTLE cycle
        go(1'b0, 16'd5);
        tick();
        glitch[0] = 1'b1;
        tick();
        glitch[0] = 1'b0;
        wait_done(n, 400);
        chk("t4_cycles", 32'(n + 2), 20);
        chk("t4_glitch", 32'(bus.err_glitch), 32'b0001);
        chk("t4_rt0", 32'(rc(0)), 5);
        chk("t4_lat0", 32'(lm(0)), 2);
        tick();
        repeat (10) tick();
        // continuous mode, ignored start mid-run, stop sampled on edge 50
        go(1'b1, 16'd0);
        repeat (19) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (29) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_done(n, 100);
        chk("t5_cycles", 32'(n), 2);
        for (int i = 0; i < CH; i++) chk($sformatf("t5_rt%0d", i), 32'(rc(i)), 13);
        repeat (20) tick();
        for (int i = 0; i < CH; i++) chk($sformatf("t5_tog%0d", i), 32'(tog[i] - t0[i]), 13);
        chk("t5_idle", 32'({bus.busy, bus.done}), 0);
        // async reset mid-WAIT, then a zero-iteration run
        go(1'b0, 16'd5);
        repeat (9) tick();
        chk("t6_pre_rt", 32'(rc(0)), 2);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_stim", 32'(bus.stim), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_rt", bus.rt_count[31:0], 0);
        chk("t6_rst_lat", 32'(bus.lat_max), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        go(1'b0, 16'd0);
        chk("t6_done", 32'(bus.done), 1);
        chk("t6_busy", 32'(bus.busy), 0);
        tick();
        chk("t6_stim", 32'(bus.stim), 0);
        for (int i = 0; i < CH; i++) chk($sformatf("t6_tog%0d", i), 32'(tog[i] - t0[i]), 0);
        chk("t6_rt", bus.rt_count[31:0], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
